weighted_rank_stream: RTL and testbench

- Parametrised streaming weighted order-statistics filter; successor to the fixed unit-weight rank-order core.
- Holds a sliding window of N samples. Each tap has its own run-time integer weight.
- For every new sample once the window is full, outputs the sample at a run-time-selected weighted rank.
- Sits between the sample source (ROM/stream) and the result store (RAM). Valid/ready handshakes on both sides replace the gated-clock feed.

---
 rtl/weighted_rank_stream.sv | 155 +++++++++++++++
 tb/tb_weighted_rank_stream.sv | 501 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weighted_rank_stream.sv
// Streaming weighted order-statistics filter. It keeps a sliding window of N
// samples and, for each completed window, emits the sample found at a
// run-time-selected weighted rank.
module weighted_rank_stream #(
  parameter int unsigned N           = 5,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned WEIGHT_BITS = 3,
  parameter int unsigned SUM_BITS    = $clog2(N * (2**WEIGHT_BITS - 1) + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_BITS-1:0]       in_data,
  input  logic [N*WEIGHT_BITS-1:0]   weights,
  input  logic [SUM_BITS-1:0]        rank,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_BITS-1:0]       out_data,
  output logic                       out_zero_weight,
  output logic                       window_full
);

  localparam int unsigned FILL_BITS = $clog2(N + 1);

  // Window and accept-time captures
  logic [DATA_BITS-1:0]   taps   [N];
  logic [FILL_BITS-1:0]   fill;
  logic [FILL_BITS-1:0]   fill_next;
  logic                   full_next;
  logic                   en;
  logic                   accept;
  logic                   p_valid;
  logic [WEIGHT_BITS-1:0] p_w    [N];
  logic [SUM_BITS-1:0]    p_rank;

  // Stage-1 snapshot
  logic                   s1_valid;
  logic [DATA_BITS-1:0]   s1_tap [N];
  logic [WEIGHT_BITS-1:0] s1_w   [N];
  logic [SUM_BITS-1:0]    s1_rank;

  // Rank selection
  logic [SUM_BITS-1:0]    total_w;
  logic [SUM_BITS-1:0]    r_eff;
  logic [SUM_BITS-1:0]    acc;
  logic [DATA_BITS-1:0]   sel_data;

  // The whole pipeline advances together whenever the output slot can move.
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign accept    = in_valid && en;
  assign fill_next = (fill == FILL_BITS'(N)) ? fill : fill + FILL_BITS'(1);
  assign full_next = (fill_next == FILL_BITS'(N));

  // Window shift register; weights and rank are captured with the sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        taps[i] <= '0;
        p_w[i]  <= '0;
      end
      fill        <= '0;
      window_full <= 1'b0;
      p_valid     <= 1'b0;
      p_rank      <= '0;
    end else if (clear) begin
      fill        <= '0;
      window_full <= 1'b0;
      p_valid     <= 1'b0;
    end else if (en) begin
      p_valid <= accept && full_next;
      if (accept) begin
        taps[0] <= in_data;
        for (int i = 1; i < N; i++) begin
          taps[i] <= taps[i-1];
        end
        for (int i = 0; i < N; i++) begin
          p_w[i] <= weights[i*WEIGHT_BITS +: WEIGHT_BITS];
        end
        p_rank      <= rank;
        fill        <= fill_next;
        window_full <= full_next;
      end
    end
  end

  // Snapshot of a completed window so the taps can keep shifting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        s1_tap[i] <= '0;
        s1_w[i]   <= '0;
      end
      s1_valid <= 1'b0;
      s1_rank  <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= p_valid;
      if (p_valid) begin
        for (int i = 0; i < N; i++) begin
          s1_tap[i] <= taps[i];
          s1_w[i]   <= p_w[i];
        end
        s1_rank <= p_rank;
      end
    end
  end

  // Tap i owns weighted positions [acc, acc + w_i), where acc sums the weights
  // of all taps ordered before it (value first, tap index breaks ties).
  always_comb begin
    total_w  = '0;
    r_eff    = '0;
    acc      = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      total_w = total_w + SUM_BITS'(s1_w[i]);
    end
    if (total_w != '0) begin
      r_eff = (s1_rank >= total_w) ? total_w - SUM_BITS'(1) : s1_rank;
    end
    for (int i = 0; i < N; i++) begin
      acc = '0;
      for (int j = 0; j < N; j++) begin
        if ((s1_tap[j] < s1_tap[i]) || ((s1_tap[j] == s1_tap[i]) && (j < i))) begin
          acc = acc + SUM_BITS'(s1_w[j]);
        end
      end
      if ((s1_w[i] != '0) && (r_eff >= acc) && (r_eff < acc + SUM_BITS'(s1_w[i]))) begin
        sel_data = s1_tap[i];
      end
    end
  end

  // Output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_zero_weight <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data        <= sel_data;
        out_zero_weight <= (total_w == '0);
      end
    end
  end

endmodule

// File: tb/tb_weighted_rank_stream.sv
// Bench for weighted_rank_stream: directed scenarios plus a randomized stream,
// scored against a sort-and-expand reference model of the weighted rank.
module tb_weighted_rank_stream;

  localparam int unsigned N         = 5;
  localparam int unsigned DW        = 8;
  localparam int unsigned WB        = 3;
  localparam int unsigned SB        = $clog2(N * (2**WB - 1) + 1);
  localparam int unsigned WV        = N * WB;
  localparam logic [WV-1:0] UNIT_W  = 15'b001_001_001_001_001;
  localparam int unsigned ZERO_FLAG = 32'h100;

  logic          clk;
  logic          rst;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [WV-1:0] weights;
  logic [SB-1:0] rank;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_zero_weight;
  logic          window_full;

  int n_checks = 0;
  int n_fail   = 0;
  int chk_idx  = 0;
  int unsigned mwin  [$];
  int unsigned exp_q [$];
  int unsigned obs_q [$];

  weighted_rank_stream #(.N(N), .DATA_BITS(DW), .WEIGHT_BITS(WB)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .weights(weights), .rank(rank),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero_weight(out_zero_weight), .window_full(window_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: list samples in (value, tap) order, repeat each by its weight,
  // then index the expanded list at the clamped rank.
  function automatic int unsigned model_result(input int unsigned win[$],
                                               input logic [WV-1:0] wv,
                                               input int unsigned rk);
    int unsigned keys[$];
    int unsigned expanded[$];
    int unsigned tap;
    int unsigned wt;
    int unsigned r;
    for (int i = 0; i < N; i++) keys.push_back(win[i] * N + i);
    keys.sort();
    foreach (keys[k]) begin
      tap = keys[k] % N;
      wt  = 32'(wv[tap*WB +: WB]);
      repeat (wt) expanded.push_back(win[tap]);
    end
    if (expanded.size() == 0) return ZERO_FLAG;
    r = (rk >= expanded.size()) ? expanded.size() - 1 : rk;
    return expanded[r];
  endfunction

  // Observes handshakes half a cycle before the edge that commits them.
  always @(negedge clk) begin
    if (!rst) begin
      mwin.delete();
      while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
    end else begin
      if (out_valid && out_ready) obs_q.push_back({23'd0, out_zero_weight, out_data});
      if (clear) begin
        mwin.delete();
        while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
      end else if (in_valid && in_ready) begin
        mwin.push_front(32'(in_data));
        if (mwin.size() > N) void'(mwin.pop_back());
        if (mwin.size() == N) exp_q.push_back(model_result(mwin, weights, 32'(rank)));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_window(input int unsigned v[N], input logic [WV-1:0] wv, input logic [SB-1:0] rk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clear     = 1'b1;
    cyc();
    clear   = 1'b0;
    weights = wv;
    rank    = rk;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(v[i]);
      cyc();
    end
    in_valid = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic test_reset();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_zero_weight !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b d=%0d z=%0b, want 0/0/0", out_valid, out_data, out_zero_weight);
    end
    n_checks++;
    if (window_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_window_full: got %0b, want 0", window_full);
    end
    rst = 1'b1;
    cyc();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %0b, want 1", in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid_after_release: got %0b, want 0", out_valid);
    end
  endtask

  task automatic test_median();
    int unsigned seq[5] = '{10, 50, 20, 40, 30};
    weights   = UNIT_W;
    rank      = SB'(2);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(seq[i]);
      cyc();
      n_checks++;
      if (out_valid !== 1'b0 || window_full !== 1'b0) begin
        n_fail++;
        $display("FAIL median_early_%0d: got v=%0b full=%0b, want 0/0", i, out_valid, window_full);
      end
    end
    in_data = DW'(seq[4]);
    cyc();
    in_valid = 1'b0;
    n_checks++;
    if (window_full !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL median_fill: got full=%0b v=%0b, want 1/0", window_full, out_valid);
    end
    cyc();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL median_latency1: got v=%0b, want 0", out_valid);
    end
    cyc();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'd30) begin
      n_fail++;
      $display("FAIL median_first: got v=%0b d=%0d, want 1/30", out_valid, out_data);
    end
    in_valid = 1'b1;
    in_data  = 8'd60;
    cyc();
    in_valid = 1'b0;
    repeat (2) cyc();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'd40) begin
      n_fail++;
      $display("FAIL median_second: got v=%0b d=%0d, want 1/40", out_valid, out_data);
    end
    repeat (2) cyc();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL median_count: got %0d results, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = chk_idx; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL median_model[%0d]: got 0x%0h, want 0x%0h", i, obs_q[i], exp_q[i]);
      end
    end
    chk_idx = obs_q.size();
  endtask

  task automatic test_weighted();
    int unsigned ranks[6] = '{2, 3, 4, 5, 0, 6};
    int unsigned want[6]  = '{30, 30, 30, 40, 10, 50};
    int unsigned last;
    for (int k = 0; k < 6; k++) begin
      load_window('{10, 50, 20, 40, 30}, 15'b001_001_001_001_011, SB'(ranks[k]));
      last = (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : 32'hFFFF_FFFF;
      n_checks++;
      if (last !== want[k]) begin
        n_fail++;
        $display("FAIL weighted_rank%0d: got 0x%0h, want %0d", ranks[k], last, want[k]);
      end
    end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL weighted_count: got %0d results, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = chk_idx; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL weighted_model[%0d]: got 0x%0h, want 0x%0h", i, obs_q[i], exp_q[i]);
      end
    end
    chk_idx = obs_q.size();
  endtask

  task automatic test_ties_clamp();
    int unsigned last;
    load_window('{7, 7, 7, 7, 7}, WV'($urandom) | WV'(1), SB'($urandom_range(0, 40)));
    last = (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : 32'hFFFF_FFFF;
    n_checks++;
    if (last !== 32'd7) begin
      n_fail++;
      $display("FAIL ties_all7: got 0x%0h, want 7", last);
    end
    load_window('{10, 50, 20, 40, 30}, UNIT_W, SB'(9));
    last = (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : 32'hFFFF_FFFF;
    n_checks++;
    if (last !== 32'd50) begin
      n_fail++;
      $display("FAIL clamp_rank9: got 0x%0h, want 50", last);
    end
    load_window('{10, 50, 20, 40, 30}, '0, SB'(3));
    last = (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : 32'hFFFF_FFFF;
    n_checks++;
    if (last !== ZERO_FLAG) begin
      n_fail++;
      $display("FAIL zero_weight: got 0x%0h, want 0x100 (flag set, data 0)", last);
    end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL ties_count: got %0d results, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = chk_idx; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ties_model[%0d]: got 0x%0h, want 0x%0h", i, obs_q[i], exp_q[i]);
      end
    end
    chk_idx = obs_q.size();
  endtask

  task automatic test_weight_change();
    int unsigned seq[5] = '{10, 50, 20, 40, 30};
    int unsigned base;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clear     = 1'b1;
    cyc();
    clear   = 1'b0;
    weights = UNIT_W;
    rank    = SB'(2);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(seq[i]);
      cyc();
    end
    base     = obs_q.size();
    weights  = 15'b001_001_000_001_001;
    in_data  = 8'd60;
    cyc();
    in_valid = 1'b0;
    repeat (5) cyc();
    n_checks++;
    if (obs_q.size() !== base + 2) begin
      n_fail++;
      $display("FAIL wchange_count: got %0d new results, want 2", obs_q.size() - base);
    end else begin
      n_checks++;
      if (obs_q[base] !== 32'd30 || obs_q[base+1] !== 32'd50) begin
        n_fail++;
        $display("FAIL wchange_values: got %0d,%0d, want 30,50", obs_q[base], obs_q[base+1]);
      end
    end
    for (int i = chk_idx; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL wchange_model[%0d]: got 0x%0h, want 0x%0h", i, obs_q[i], exp_q[i]);
      end
    end
    chk_idx = obs_q.size();
  endtask

  task automatic test_backpressure();
    logic          stall;
    logic [DW-1:0] held_d;
    for (int c = 0; c < 200; c++) begin
      in_valid  = (c < 40) ? 1'b1 : ($urandom_range(0, 9) < 8);
      in_data   = DW'($urandom);
      weights   = WV'($urandom);
      rank      = SB'($urandom_range(0, 40));
      stall     = (c >= 30 && c < 34);
      out_ready = stall ? 1'b0 : ((c < 50) ? 1'b1 : ($urandom_range(0, 9) != 0));
      held_d    = '0;
      if (stall) begin
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_ready_c%0d: got in_ready=%0b v=%0b, want 0/1", c, in_ready, out_valid);
        end
        held_d = out_data;
      end
      cyc();
      if (stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== held_d) begin
          n_fail++;
          $display("FAIL stall_hold_c%0d: got v=%0b d=%0d, want 1/%0d", c, out_valid, out_data, held_d);
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) cyc();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL stream_count: got %0d results, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = chk_idx; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stream_model[%0d]: got 0x%0h, want 0x%0h", i, obs_q[i], exp_q[i]);
      end
    end
    chk_idx = obs_q.size();
  endtask

  task automatic test_clear();
    int unsigned base;
    weights   = UNIT_W;
    rank      = SB'(2);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      cyc();
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_pre_valid: got %0b, want 1", out_valid);
    end
    clear   = 1'b1;
    in_data = 8'd99;
    cyc();
    clear    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || window_full !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_flush: got v=%0b full=%0b, want 0/0", out_valid, window_full);
    end
    base = obs_q.size();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    repeat (4) cyc();
    n_checks++;
    if (obs_q.size() !== base || window_full !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_refill4: got %0d results full=%0b, want 0/0", obs_q.size() - base, window_full);
    end
    in_valid = 1'b1;
    in_data  = DW'($urandom);
    cyc();
    in_valid = 1'b0;
    repeat (4) cyc();
    n_checks++;
    if (obs_q.size() !== base + 1 || window_full !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_refill5: got %0d results full=%0b, want 1/1", obs_q.size() - base, window_full);
    end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL clear_count: got %0d results, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = chk_idx; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL clear_model[%0d]: got 0x%0h, want 0x%0h", i, obs_q[i], exp_q[i]);
      end
    end
    chk_idx = obs_q.size();
  endtask

  task automatic test_async_reset();
    int unsigned base;
    weights   = UNIT_W;
    rank      = SB'(2);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = DW'($urandom_range(1, 255));
      cyc();
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_data === '0) begin
      n_fail++;
      $display("FAIL areset_pre: got v=%0b d=%0d, want 1/nonzero", out_valid, out_data);
    end
    #2;
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_zero_weight !== 1'b0 || window_full !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_now: got v=%0b d=%0d z=%0b full=%0b, want 0/0/0/0",
               out_valid, out_data, out_zero_weight, window_full);
    end
    cyc();
    rst = 1'b1;
    cyc();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_ready: got %0b, want 1", in_ready);
    end
    base = obs_q.size();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    repeat (4) cyc();
    n_checks++;
    if (obs_q.size() !== base || window_full !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_refill4: got %0d results full=%0b, want 0/0", obs_q.size() - base, window_full);
    end
    in_valid = 1'b1;
    in_data  = DW'($urandom);
    cyc();
    in_valid = 1'b0;
    repeat (4) cyc();
    n_checks++;
    if (obs_q.size() !== exp_q.size() || obs_q.size() !== base + 1) begin
      n_fail++;
      $display("FAIL areset_count: got %0d results, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = chk_idx; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL areset_model[%0d]: got 0x%0h, want 0x%0h", i, obs_q[i], exp_q[i]);
      end
    end
    chk_idx = obs_q.size();
  endtask

  initial begin
    rst       = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    weights   = '0;
    rank      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_median();
    test_weighted();
    test_ties_clamp();
    test_weight_change();
    test_backpressure();
    test_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
